datacapture_playback: RTL
=========================

# datacapture_playback

Host-loaded sample player that drives the filter input path, the counterpart of the capture core: where capture records `filter_input` and `filter_output` into a buffer on a trigger, this block replays a stored 14-bit sequence into `filter_input` at the `clk_enable` rate. It sits between the host/JTAG write side and the filter under test. It emits a one-cycle `capture_start` pulse aligned to the first replayed sample, which arms the capture core, so stimulus and response line up sample-for-sample.

## Interface
- DATA_WIDTH, 14, sample width (matches `filter_input`)
- ADDR_WIDTH, 10, sample memory depth is 2^ADDR_WIDTH
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clk_enable  in  1  sample-rate enable; playback advances only when high
- wr_en  in  1  host write strobe into sample memory
- wr_addr  in  ADDR_WIDTH  host write address
- wr_data  in  DATA_WIDTH  host write data
- start  in  1  level sampled each clk; starts playback from IDLE
- stop  in  1  aborts playback
- loop_en  in  1  1 = wrap to sample 0 after the last sample; sampled every cycle
- play_length  in  ADDR_WIDTH+1  number of samples per pass, latched on start
- filter_input  out  DATA_WIDTH  replayed sample, registered
- sample_valid  out  1  high for one clk when `filter_input` is updated
- capture_start  out  1  one-clk pulse with the first sample of the first pass
- busy  out  1  high in PRIME and PLAY
- done  out  1  one-clk pulse at normal end of a non-looping pass

## Operation
- Memory: simple dual-port, 2^ADDR_WIDTH x DATA_WIDTH, synchronous read with 1-cycle latency. The write port is always active, including while busy. A write is visible to reads issued on later cycles. Memory is not cleared by reset.
- FSM states: IDLE, PRIME, PLAY.
- IDLE:
  - start=1, stop=0, latched length L≠0 → PRIME.
  - start=1 with L=0 → done pulse next cycle, stay IDLE.
  - play_length > 2^ADDR_WIDTH saturates to L=2^ADDR_WIDTH.
- PRIME: exactly one clk. Issues the read of address 0 and sets read index to 0 → PLAY. This state is independent of clk_enable.
- PLAY: on each clk_enable=1 cycle:
  - `filter_input` ← mem[idx] and sample_valid=1 on the next edge.
  - idx advances and the prefetch of the next address is issued in the same cycle, so back-to-back enables sustain one sample per clk.
- End of pass, when the sample with idx=L-1 is presented:
  - loop_en=1 → idx wraps to 0 and playback continues seamlessly, with no gap cycle and no capture_start.
  - loop_en=0 → next state IDLE. done pulses in the same cycle as that final sample_valid.
- `filter_input` holds its last value between enables and after a normal end. It is forced to 0 only by reset or stop.
- capture_start is asserted in the same cycle as sample_valid for idx=0 of the first pass only.
- stop=1 in PRIME or PLAY → IDLE next edge. `filter_input` becomes 0, sample_valid=0, and no done pulse is generated.
- start while busy is ignored. start and stop in the same cycle: stop wins, so the block stays in or returns to IDLE.

## Timing
- Reset values: filter_input=0, sample_valid=0, capture_start=0, busy=0, done=0, state=IDLE, idx=0.
- Start latency:
  - start sampled at edge N → busy=1 from N.
  - PRIME occupies cycle N..N+1.
  - The first sample updates on the first edge after a cycle in PLAY with clk_enable=1. The earliest is edge N+2, assuming clk_enable is held high.
- Throughput: one sample per clk_enable-high cycle, up to one per clk.
- Pass of L samples with clk_enable constantly 1: sample_valid is high for L consecutive clks, and busy drops on the edge of the last sample.
- Reset mid-playback: all outputs return to reset values asynchronously, and memory contents are retained.

## Test plan
- Load mem[i]=i+100 for i=0..7, L=8, loop_en=0, clk_enable=1 → filter_input reads 100..107 on 8 consecutive clks starting 2 clks after start. capture_start coincides with 100, done coincides with 107, and busy=0 afterwards.
- Same load, clk_enable high every 4th clk → each sample held 4 clks. sample_valid pulses only on update edges, and the value sequence is unchanged.
- loop_en=1, L=3, data {5,6,7} → output 5,6,7,5,6,7,… with no gap and a single capture_start. Dropping loop_en during the second pass → ends after 7 with done.
- stop asserted after the 3rd sample → next edge filter_input=0, busy=0, done stays 0. start+stop in the same cycle from IDLE → no activity.
- L=0 start → done pulse, busy never set. L=2^ADDR_WIDTH+5 → exactly 2^ADDR_WIDTH samples replayed.
- rst_n low during PLAY → outputs 0 immediately. Restart after reset replays the pre-reset memory contents intact.

Source files
------------

// File: rtl/datacapture_playback.sv
// datacapture_playback
//
// Replays a host-loaded sequence of samples into the filter input path at the
// clk_enable rate.  The host fills a dual-port sample memory through the write
// port at any time.  A start request latches the pass length and primes the
// memory read pipeline, then one sample is presented per enabled cycle.  The
// first sample of the first pass carries a capture_start pulse that arms the
// capture core, so stimulus and response line up sample-for-sample.
//
// Ports:
//   clk, rst_n      single rising-edge clock, asynchronous active-low reset
//   clk_enable      sample-rate enable; playback advances only when high
//   wr_en/addr/data host write port into the sample memory
//   start, stop     start playback from idle / abort playback
//   loop_en         wrap to sample 0 after the last sample of a pass
//   play_length     samples per pass, latched on start (saturates at depth)
//   filter_input    replayed sample, registered
//   sample_valid    one-cycle strobe when filter_input updates
//   capture_start   one-cycle strobe with the first sample of the first pass
//   busy            high while priming or playing
//   done            one-cycle strobe at the normal end of a non-looping pass
module datacapture_playback #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH:0]   play_length,
    output logic [DATA_WIDTH-1:0] filter_input,
    output logic                  sample_valid,
    output logic                  capture_start,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        PLAY
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH:0]   sat_len;
    logic                  first_pass;

    // Oversized lengths clamp to the full memory depth.
    assign sat_len = (play_length > MAX_LEN) ? MAX_LEN : play_length;

    // Index of the sample to prefetch after the one now sitting in rd_data.
    assign next_idx = (idx == last_idx && loop_en) ? '0 : idx + 1'b1;

    // The read address normally re-reads the pending index, so rd_data always
    // holds mem[idx] (including host writes made while waiting for an enable).
    // Priming reads sample 0; an enabled cycle prefetches the next sample so
    // back-to-back enables sustain one sample per clock.
    always_comb begin
        rd_addr = idx;
        if (state == PRIME) begin
            rd_addr = '0;
        end else if (state == PLAY && clk_enable) begin
            rd_addr = next_idx;
        end
    end

    // Sample memory: not reset, write port always live, one-cycle read.
    // A same-cycle write and read of one address returns the old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Playback control.  Strobes default low every cycle; stop from a busy
    // state overrides everything else, including an enable in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            last_idx      <= '0;
            first_pass    <= 1'b0;
            filter_input  <= '0;
            sample_valid  <= 1'b0;
            capture_start <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            sample_valid  <= 1'b0;
            capture_start <= 1'b0;
            done          <= 1'b0;
            if (state != IDLE && stop) begin
                state        <= IDLE;
                busy         <= 1'b0;
                filter_input <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            if (sat_len == '0) begin
                                done <= 1'b1;
                            end else begin
                                last_idx <= ADDR_WIDTH'(sat_len - 1'b1);
                                busy     <= 1'b1;
                                state    <= PRIME;
                            end
                        end
                    end
                    PRIME: begin
                        idx        <= '0;
                        first_pass <= 1'b1;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (clk_enable) begin
                            filter_input  <= rd_data;
                            sample_valid  <= 1'b1;
                            capture_start <= first_pass;
                            first_pass    <= 1'b0;
                            idx           <= next_idx;
                            if (idx == last_idx && !loop_en) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
